// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction prefetch into a DEPTH-entry show-ahead FIFO.
// Ports: clk/rst, RST_VEC, redirect/redirect_PC, mem_req/mem_addr/mem_gnt/MDB_out,
//        instr_valid/instr_word/instr_addr/instr_take, count.
module fetch_queue #(
   parameter int SIZE  = 16,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [SIZE-1:0]              RST_VEC,
   input  logic                         redirect,
   input  logic [SIZE-1:0]              redirect_PC,
   output logic                         mem_req,
   output logic [SIZE-1:0]              mem_addr,
   input  logic                         mem_gnt,
   input  logic [SIZE-1:0]              MDB_out,
   output logic                         instr_valid,
   output logic [SIZE-1:0]              instr_word,
   output logic [SIZE-1:0]              instr_addr,
   input  logic                         instr_take,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

   logic [SIZE-1:0] fpc;
   logic [SIZE-1:0] lat_addr;
   logic [SIZE-1:0] mem_w [DEPTH];
   logic [SIZE-1:0] mem_a [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic            inflight;
   logic [CW:0]     occ;
   logic            grant;
   logic            do_wr;
   logic            do_rd;

   // Outstanding fetch reserves a slot so a return never overflows.
   assign occ      = {1'b0, count} + (CW+1)'(inflight);
   assign mem_req  = !rst && !redirect && (occ < FULL);
   assign mem_addr = fpc;
   assign grant    = mem_req && mem_gnt;
   assign do_wr    = inflight;
   assign do_rd    = instr_take && instr_valid;

   assign instr_valid = (count != '0);
   assign instr_word  = instr_valid ? mem_w[rd_ptr] : '0;
   assign instr_addr  = instr_valid ? mem_a[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc      <= {RST_VEC[SIZE-1:1], 1'b0};
         lat_addr <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         inflight <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_w[i] <= '0;
            mem_a[i] <= '0;
         end
      end else if (redirect) begin
         // Pending return and any same-cycle take are dropped.
         fpc      <= {redirect_PC[SIZE-1:1], 1'b0};
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= grant;
         if (grant) begin
            fpc      <= fpc + SIZE'(2);
            lat_addr <= fpc;
         end
         if (do_wr) begin
            mem_w[wr_ptr] <= MDB_out;
            mem_a[wr_ptr] <= lat_addr;
            wr_ptr        <= wr_ptr + AW'(1);
         end
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed tests for fetch_queue (SIZE=16, DEPTH=4).
// Memory model returns word = granted address one cycle after the grant.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] RST_VEC;
   logic        redirect;
   logic [15:0] redirect_PC;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_gnt;
   logic [15:0] MDB_out = 16'hDEAD;
   logic        instr_valid;
   logic [15:0] instr_word;
   logic [15:0] instr_addr;
   logic        instr_take;
   logic [2:0]  count;

   int checks   = 0;
   int failures = 0;

   fetch_queue #(.SIZE(16), .DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .RST_VEC     (RST_VEC),
      .redirect    (redirect),
      .redirect_PC (redirect_PC),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_gnt     (mem_gnt),
      .MDB_out     (MDB_out),
      .instr_valid (instr_valid),
      .instr_word  (instr_word),
      .instr_addr  (instr_addr),
      .instr_take  (instr_take),
      .count       (count)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      MDB_out <= (mem_req && mem_gnt) ? mem_addr : 16'hDEAD;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; RST_VEC = 16'hF001; redirect = 1'b0;
      redirect_PC = 16'h0; mem_gnt = 1'b1; instr_take = 1'b0;
      tick(); tick();
      #1;
      checks++;
      if (mem_req !== 1'b0) begin
         failures++;
         $display("FAIL rst_mem_req got=%b exp=0", mem_req);
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'hF000) begin
         failures++;
         $display("FAIL first_fetch got=%b/%h exp=1/f000", mem_req, mem_addr);
      end
      checks++;
      if (instr_valid !== 1'b0 || instr_word !== 16'h0 ||
          instr_addr !== 16'h0 || count !== 3'd0) begin
         failures++;
         $display("FAIL reset_outs got=%b %h %h %0d exp=0 0 0 0",
                  instr_valid, instr_word, instr_addr, count);
      end
   endtask

   task automatic test_fill();
      tick();
      #1;
      checks++;
      if (instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL valid_early got=%b exp=0", instr_valid);
      end
      tick();
      #1;
      checks++;
      if (instr_valid !== 1'b1 || instr_word !== 16'hF000 ||
          instr_addr !== 16'hF000) begin
         failures++;
         $display("FAIL first_word got=%b %h %h exp=1 f000 f000",
                  instr_valid, instr_word, instr_addr);
      end
      tick(); tick();
      #1;
      checks++;
      if (mem_req !== 1'b0) begin
         failures++;
         $display("FAIL full_stop_req got=%b exp=0", mem_req);
      end
      tick();
      #1;
      checks++;
      if (count !== 3'd4 || mem_req !== 1'b0) begin
         failures++;
         $display("FAIL filled got=%0d/%b exp=4/0", count, mem_req);
      end
   endtask

   task automatic test_drain();
      logic [15:0] exp;
      exp = 16'hF000;
      instr_take = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if (instr_valid !== 1'b1 || instr_word !== exp ||
             instr_addr !== exp || count > 3'd4) begin
            failures++;
            $display("FAIL drain_%0d got=%b %h %h %0d exp=1 %h %h <=4",
                     i, instr_valid, instr_word, instr_addr, count, exp, exp);
         end
         if (i == 0) begin
            checks++;
            if (mem_req !== 1'b0) begin
               failures++;
               $display("FAIL no_bypass got=%b exp=0", mem_req);
            end
         end
         exp = exp + 16'd2;
         tick();
      end
      instr_take = 1'b0;
      #1;
      checks++;
      if (count !== 3'd2 || instr_word !== 16'hF00C) begin
         failures++;
         $display("FAIL after_drain got=%0d %h exp=2 f00c", count, instr_word);
      end
   endtask

   task automatic test_redirect();
      redirect = 1'b1; redirect_PC = 16'h1235;
      #1;
      checks++;
      if (mem_req !== 1'b0) begin
         failures++;
         $display("FAIL redir_req got=%b exp=0", mem_req);
      end
      tick();
      redirect = 1'b0;
      #1;
      checks++;
      if (count !== 3'd0 || instr_valid !== 1'b0 ||
          mem_req !== 1'b1 || mem_addr !== 16'h1234) begin
         failures++;
         $display("FAIL redir_next got=%0d %b %b %h exp=0 0 1 1234",
                  count, instr_valid, mem_req, mem_addr);
      end
      tick(); tick();
      #1;
      checks++;
      if (instr_valid !== 1'b1 || instr_addr !== 16'h1234 ||
          instr_word !== 16'h1234 || count !== 3'd1) begin
         failures++;
         $display("FAIL redir_head got=%b %h %h %0d exp=1 1234 1234 1",
                  instr_valid, instr_addr, instr_word, count);
      end
   endtask

   task automatic test_wrap();
      logic [15:0] exp_a [4];
      exp_a[0] = 16'hFFFC; exp_a[1] = 16'hFFFE;
      exp_a[2] = 16'h0000; exp_a[3] = 16'h0002;
      redirect = 1'b1; redirect_PC = 16'hFFFC;
      tick();
      redirect = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (mem_req !== 1'b1 || mem_addr !== exp_a[i]) begin
            failures++;
            $display("FAIL wrap_%0d got=%b %h exp=1 %h",
                     i, mem_req, mem_addr, exp_a[i]);
         end
         tick();
      end
   endtask

   task automatic test_stall_simul();
      redirect = 1'b1; redirect_PC = 16'h2000; mem_gnt = 1'b0;
      tick();
      redirect = 1'b0; mem_gnt = 1'b1;
      #1;
      checks++;
      if (mem_addr !== 16'h2000) begin
         failures++;
         $display("FAIL stall_a0 got=%h exp=2000", mem_addr);
      end
      tick();
      mem_gnt = 1'b0;
      tick();
      #1;
      checks++;
      if (mem_addr !== 16'h2002 || count !== 3'd1) begin
         failures++;
         $display("FAIL stall_hold got=%h %0d exp=2002 1", mem_addr, count);
      end
      mem_gnt = 1'b1;
      tick();
      instr_take = 1'b1; mem_gnt = 1'b0;
      #1;
      checks++;
      if (count !== 3'd1 || instr_word !== 16'h2000 || mem_addr !== 16'h2004) begin
         failures++;
         $display("FAIL pre_simul got=%0d %h %h exp=1 2000 2004",
                  count, instr_word, mem_addr);
      end
      tick();
      #1;
      checks++;
      if (count !== 3'd1 || instr_word !== 16'h2002 || mem_addr !== 16'h2004) begin
         failures++;
         $display("FAIL simul got=%0d %h %h exp=1 2002 2004",
                  count, instr_word, mem_addr);
      end
      tick();
      #1;
      checks++;
      if (count !== 3'd0 || instr_valid !== 1'b0) begin
         failures++;
         $display("FAIL drain_last got=%0d %b exp=0 0", count, instr_valid);
      end
      tick();
      instr_take = 1'b0;
      #1;
      checks++;
      if (count !== 3'd0 || instr_word !== 16'h0) begin
         failures++;
         $display("FAIL empty_take got=%0d %h exp=0 0", count, instr_word);
      end
   endtask

   task automatic test_reset_mid();
      mem_gnt = 1'b1;
      tick(); tick(); tick(); tick();
      #1;
      checks++;
      if (count !== 3'd3 || mem_req !== 1'b0) begin
         failures++;
         $display("FAIL mid_setup got=%0d %b exp=3 0", count, mem_req);
      end
      rst = 1'b1; RST_VEC = 16'h4567;
      tick();
      #1;
      checks++;
      if (instr_valid !== 1'b0 || count !== 3'd0 || mem_req !== 1'b0) begin
         failures++;
         $display("FAIL mid_rst got=%b %0d %b exp=0 0 0",
                  instr_valid, count, mem_req);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h4566) begin
         failures++;
         $display("FAIL mid_restart got=%b %h exp=1 4566", mem_req, mem_addr);
      end
      tick();
      #1;
      checks++;
      if (count !== 3'd0) begin
         failures++;
         $display("FAIL mid_dropped got=%0d exp=0", count);
      end
      tick();
      #1;
      checks++;
      if (instr_valid !== 1'b1 || instr_addr !== 16'h4566) begin
         failures++;
         $display("FAIL mid_head got=%b %h exp=1 4566", instr_valid, instr_addr);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_redirect();
      test_wrap();
      test_stall_simul();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction prefetch buffer between the memory port and `instr_dec`. It fetches sequential instruction words ahead of the decoder over the shared MAB/MDB path and holds them in a DEPTH-entry show-ahead FIFO together with each word's address. The decoder consumes words with a take strobe. A PC redirect (jump, call, return, interrupt) flushes the queue, discards any in-flight fetch and restarts fetching at the new address.

## Interface

Parameters:
- SIZE, 16, data and address width in bits.
- DEPTH, 4, queue entries. Must be a power of two and ≥ 2.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- RST_VEC  in  SIZE  fetch start address loaded during reset.
- redirect  in  1  flush the queue and restart fetching at redirect_PC.
- redirect_PC  in  SIZE  new fetch address; bit 0 is ignored.
- mem_req  out  1  fetch request for the memory port.
- mem_addr  out  SIZE  fetch address driven onto MAB while mem_req=1.
- mem_gnt  in  1  memory port granted to fetch this cycle.
- MDB_out  in  SIZE  memory read data, valid the cycle after a grant.
- instr_valid  out  1  queue head holds a valid word.
- instr_word  out  SIZE  head instruction word.
- instr_addr  out  SIZE  address of the head word.
- instr_take  in  1  decoder consumes the head this cycle.
- count  out  clog2(DEPTH+1)  number of valid entries.

## Operation

- State:
  - fetch pointer fpc.
  - storage mem_w[DEPTH] and mem_a[DEPTH].
  - read pointer rd_ptr and write pointer wr_ptr, each log2(DEPTH) bits, wrapping naturally.
  - count.
  - inflight flag (1 = a grant occurred in the previous cycle and is not killed).
- Request: mem_req = !redirect && (count + inflight < DEPTH). mem_addr = fpc.
- Grant: when mem_req && mem_gnt at an edge:
  - fpc ← fpc + 2, modulo 2^SIZE (0xFFFE wraps to 0x0000 at SIZE=16);
  - inflight ← 1 and the granted address is latched;
  - otherwise inflight ← 0.
- Return: in a cycle with inflight=1 and no redirect, MDB_out and the latched address are written at wr_ptr, and wr_ptr increments.
- Take: instr_take && instr_valid increments rd_ptr. instr_take while empty is ignored.
- Count: +1 on write only, −1 on take only, unchanged when both happen in the same cycle.
- Head outputs: instr_valid = (count≠0). instr_word and instr_addr are read from rd_ptr (registered storage, combinational read). When empty, both read 0.
- Redirect, applied at the edge:
  - count, rd_ptr, wr_ptr and inflight are cleared;
  - fpc ← {redirect_PC[SIZE-1:1], 0};
  - data returning in the redirect cycle is discarded;
  - a simultaneous take is discarded.
- Priority: rst > redirect > write/take.
- Reset values: fpc = {RST_VEC[SIZE-1:1], 0}; count = 0; pointers and inflight = 0; storage = 0. Outputs after reset: instr_valid=0, instr_word=0, instr_addr=0, count=0. mem_req=1 in the first cycle after reset (a combinational function of the reset state). While rst=1, mem_req=0.
- Reset mid-operation: same as a redirect to RST_VEC. The in-flight return is dropped.

## Timing

- Sequential fetch latency: request granted in cycle t → data on MDB_out in t+1 → instr_valid=1 from t+2.
- Throughput: with mem_gnt held at 1, one word per cycle into the queue.
- Redirect latency: redirect in cycle t → mem_req=1 with the new address in t+1 → first valid word at t+3.
- Full condition: with count + inflight = DEPTH, mem_req=0. A take in that same cycle re-enables mem_req in the next cycle only (no same-cycle bypass).
- Simultaneous write and take when count = DEPTH−1 or 1: count unchanged, no overflow or underflow.
- mem_gnt while mem_req=0 is ignored.

## Test plan

- Reset and sequential fill:
  - Stimulus: RST_VEC=0xF001, DEPTH=4, mem_gnt=1, memory returns word = address.
  - Required: first mem_addr=0xF000; instr_valid rises 2 cycles after reset release; queue fills to count=4 with addresses F000, F002, F004, F006; mem_req then 0.
- Drain and refill:
  - Stimulus: full queue; hold instr_take=1 for 6 cycles.
  - Required: words 0xF000–0xF00A delivered in order; count never exceeds 4; no duplicates or gaps.
- Redirect with a fetch in flight:
  - Stimulus: redirect=1, redirect_PC=0x1235 in a cycle with a return pending.
  - Required: the returned word is not enqueued; count=0 next cycle; next mem_addr=0x1234; instr_addr=0x1234 three cycles after the redirect.
- Address wrap:
  - Stimulus: redirect to 0xFFFC.
  - Required: fetch addresses 0xFFFC, 0xFFFE, 0x0000, 0x0002.
- Stalled grant and simultaneous events:
  - Stimulus: mem_gnt toggled 1-0-1, with instr_take on the same edge as a write at count=1.
  - Required: fpc advances only on granted cycles; count stays 1; take on an empty queue leaves count=0.
- Reset mid-stream:
  - Stimulus: assert rst with count=3 and inflight=1.
  - Required: next cycle instr_valid=0, count=0; after release, the first mem_addr = RST_VEC with bit 0 cleared.
